// File: rtl/mp4_top.sv
// Memory-side arbiter and cacheline adapter: serialises icache/dcache 256-bit line
// requests onto one 64-bit 4-beat burst port. Optional `ARB_ROUND_ROBIN_EN` alternates ties.
module mp4_top #(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_read,
  input  logic [31:0]          i_addr,
  output logic [LINE_BITS-1:0] i_rdata,
  output logic                 i_resp,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [31:0]          d_addr,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic                 d_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [31:0]          pmem_address,
  output logic [BEAT_BITS-1:0] pmem_wdata,
  input  logic [BEAT_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);

  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {IDLE, I_READ, D_READ, D_WRITE, DONE} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         beat_reg, beat_next;
  logic [31:0]           addr_reg, addr_next;
  logic [LINE_BITS-1:0]  wline_reg, wline_next;
  logic [LINE_BITS-1:0]  buf_reg, buf_next;
  logic [LINE_BITS-1:0]  i_rdata_reg, i_rdata_next;
  logic [LINE_BITS-1:0]  d_rdata_reg, d_rdata_next;
  // Requester of the current (or most recent) transfer; doubles as round-robin state.
  logic                  served_d_reg, served_d_next;

  logic [LINE_BITS-1:0]  buf_merged;
  logic [BEAT_BITS-1:0]  wbeats [BEATS];
  logic                  last_beat;
  logic                  d_pending;
  logic                  pick_i;

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      assign buf_merged[gi*BEAT_BITS +: BEAT_BITS] =
        (beat_reg == CW'(gi)) ? pmem_rdata : buf_reg[gi*BEAT_BITS +: BEAT_BITS];
      assign wbeats[gi] = wline_reg[gi*BEAT_BITS +: BEAT_BITS];
    end
  endgenerate

  assign last_beat = (beat_reg == CW'(BEATS - 1));
  assign d_pending = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  assign pick_i = i_read & (~d_pending | served_d_reg);
`else
  assign pick_i = i_read & ~d_pending;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      beat_reg     <= '0;
      addr_reg     <= '0;
      wline_reg    <= '0;
      buf_reg      <= '0;
      i_rdata_reg  <= '0;
      d_rdata_reg  <= '0;
      served_d_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      beat_reg     <= beat_next;
      addr_reg     <= addr_next;
      wline_reg    <= wline_next;
      buf_reg      <= buf_next;
      i_rdata_reg  <= i_rdata_next;
      d_rdata_reg  <= d_rdata_next;
      served_d_reg <= served_d_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    beat_next     = beat_reg;
    addr_next     = addr_reg;
    wline_next    = wline_reg;
    buf_next      = buf_reg;
    i_rdata_next  = i_rdata_reg;
    d_rdata_next  = d_rdata_reg;
    served_d_next = served_d_reg;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_wdata    = '0;
    i_resp        = 1'b0;
    d_resp        = 1'b0;

    case (state_reg)
      IDLE: begin
        beat_next = '0;
        if (pick_i) begin
          state_next    = I_READ;
          addr_next     = i_addr;
          served_d_next = 1'b0;
        end else if (d_read) begin
          state_next    = D_READ;
          addr_next     = d_addr;
          served_d_next = 1'b1;
        end else if (d_write) begin
          state_next    = D_WRITE;
          addr_next     = d_addr;
          wline_next    = d_wdata;
          served_d_next = 1'b1;
        end
      end
      I_READ, D_READ: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          buf_next  = buf_merged;
          beat_next = beat_reg + CW'(1);
          if (last_beat) begin
            state_next = DONE;
            // Publish the complete line so the port shows it during DONE and holds it after.
            if (state_reg == I_READ) i_rdata_next = buf_merged;
            else                     d_rdata_next = buf_merged;
          end
        end
      end
      D_WRITE: begin
        pmem_write = 1'b1;
        pmem_wdata = wbeats[beat_reg];
        if (pmem_resp) begin
          beat_next = beat_reg + CW'(1);
          if (last_beat) state_next = DONE;
        end
      end
      DONE: begin
        i_resp     = ~served_d_reg;
        d_resp     = served_d_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign pmem_address = addr_reg & ~32'(LINE_BITS / 8 - 1);
  assign i_rdata      = i_rdata_reg;
  assign d_rdata      = d_rdata_reg;

endmodule

// File: tb/tb_mp4_top.sv
// Scoreboard bench for mp4_top: directed bursts, expected responses queued at issue time
// and checked by a negedge monitor whenever i_resp or d_resp fires.
module tb_mp4_top;

  logic         clk;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_addr;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic [63:0]  pmem_rdata;
  logic         pmem_resp;

  mp4_top dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    logic         is_d;
    logic         chk_data;
    logic [255:0] data;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per completion pulse.
  always @(negedge clk) begin
    if (i_resp || d_resp) begin
      exp_t e;
      chk("resp_exclusive", 256'(i_resp & d_resp), 256'(0));
      if (q.size() == 0) begin
        chk("unexpected_resp", 256'({i_resp, d_resp}), 256'(0));
      end else begin
        e = q.pop_front();
        chk("resp_port", 256'({i_resp, d_resp}), e.is_d ? 256'(2'b01) : 256'(2'b10));
        if (e.chk_data) chk("resp_line", e.is_d ? d_rdata : i_rdata, e.data);
      end
    end
  end

  // One memory beat: optional idle gap, wait for a burst request, check it, acknowledge.
  task automatic do_beat(input logic [63:0] rd, input int gap, input logic [31:0] exp_addr,
                         input logic is_wr, input logic [63:0] exp_wd);
    int n;
    pmem_resp = 1'b0;
    repeat (gap) tick();
    n = 0;
    while (!(pmem_read || pmem_write) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      chk("burst_request_timeout", 256'(n), 256'(0));
    end else begin
      pmem_rdata = rd;
      pmem_resp  = 1'b1;
      @(negedge clk);
      chk("pmem_address", 256'(pmem_address), 256'(exp_addr));
      chk("pmem_rw", 256'({pmem_read, pmem_write}), is_wr ? 256'(2'b01) : 256'(2'b10));
      if (is_wr) chk("pmem_wdata", 256'(pmem_wdata), 256'(exp_wd));
      tick();
      pmem_resp = 1'b0;
    end
  endtask

  // Waits for the completion pulse; returns at the edge leaving DONE (+1).
  task automatic wait_resp(output int c1);
    int n;
    n = 0;
    @(negedge clk);
    while (!(i_resp || d_resp) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("resp_timeout", 256'(n), 256'(0));
    c1 = cyc;
    tick();
  endtask

  task automatic resp_low();
    @(negedge clk);
    chk("resp_one_cycle", 256'({i_resp, d_resp}), 256'(0));
  endtask

  task automatic read_line(input logic [255:0] line, input int gap, input logic [31:0] a);
    for (int k = 0; k < 4; k++) do_beat(line[k*64 +: 64], gap, a, 1'b0, 64'd0);
  endtask

  logic [255:0] l1, wl, dl, il, gl, rl;
  logic         d_first;
  int           c0, c1;

  initial begin
    rst = 1'b0; i_read = 0; i_addr = 0; d_read = 0; d_write = 0; d_addr = 0;
    d_wdata = 0; pmem_rdata = 0; pmem_resp = 0;
    l1 = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    wl = 256'h0123456789abcdef_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0_fedcba987654fedc;
    dl = {64'hdddddddddddddddd, 64'hcccccccccccccccc, 64'hbbbbbbbbbbbbbbbb, 64'haaaaaaaaaaaaaaaa};
    il = {64'h8888888888888888, 64'h7777777777777777, 64'h6666666666666666, 64'h5555555555555555};
    gl = {64'h0f0f0f0f0f0f0f04, 64'h0f0f0f0f0f0f0f03, 64'h0f0f0f0f0f0f0f02, 64'h0f0f0f0f0f0f0f01};
    rl = {64'h9abc000000000004, 64'h9abc000000000003, 64'h9abc000000000002, 64'h9abc000000000001};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pmem_rw", 256'({pmem_read, pmem_write}), 256'(0));
    chk("reset_resp", 256'({i_resp, d_resp}), 256'(0));
    chk("reset_address", 256'(pmem_address), 256'(0));
    chk("reset_i_rdata", i_rdata, 256'(0));
    tick();
    rst = 1'b1;
    tick();

    // Icache fill, consecutive beats, latency 6.
    c0 = cyc;
    i_read = 1; i_addr = 32'h0000_0064;
    q.push_back('{1'b0, 1'b1, l1});
    read_line(l1, 0, 32'h0000_0060);
    wait_resp(c1);
    i_read = 0;
    chk("icache_latency", 256'(c1 - c0 + 1), 256'(6));
    resp_low();

    // Dcache write-back.
    d_write = 1; d_addr = 32'h8000_00a4; d_wdata = wl;
    q.push_back('{1'b1, 1'b0, 256'(0)});
    for (int k = 0; k < 4; k++) do_beat(64'd0, 0, 32'h8000_00a0, 1'b1, wl[k*64 +: 64]);
    wait_resp(c1);
    d_write = 0;
    resp_low();

    // Tie between i_read and d_read.
`ifdef ARB_ROUND_ROBIN_EN
    d_first = 1'b0;
`else
    d_first = 1'b1;
`endif
    d_read = 1; d_addr = 32'h0000_1000;
    i_read = 1; i_addr = 32'h0000_2008;
    if (d_first) begin
      q.push_back('{1'b1, 1'b1, dl});
      q.push_back('{1'b0, 1'b1, il});
      read_line(dl, 0, 32'h0000_1000);
    end else begin
      q.push_back('{1'b0, 1'b1, il});
      q.push_back('{1'b1, 1'b1, dl});
      read_line(il, 0, 32'h0000_2000);
    end
    wait_resp(c1);
    if (d_first) d_read = 0; else i_read = 0;
    resp_low();
    chk("idle_after_done", 256'(pmem_read), 256'(0));
    tick();
    chk("second_grant_read", 256'(pmem_read), 256'(1));
    chk("second_grant_addr", 256'(pmem_address), d_first ? 256'(32'h0000_2000) : 256'(32'h0000_1000));
    if (d_first) read_line(il, 0, 32'h0000_2000);
    else         read_line(dl, 0, 32'h0000_1000);
    wait_resp(c1);
    i_read = 0; d_read = 0;
    resp_low();

    // Gapped beats with the request address changing mid-burst.
    i_read = 1; i_addr = 32'h1234_5678;
    q.push_back('{1'b0, 1'b1, gl});
    for (int k = 0; k < 4; k++) begin
      do_beat(gl[k*64 +: 64], 2, 32'h1234_5660, 1'b0, 64'd0);
      if (k == 1) i_addr = 32'hffff_ffe0;
    end
    wait_resp(c1);
    i_read = 0;
    resp_low();
    chk("d_rdata_hold", d_rdata, dl);

    // Reset in the middle of a burst.
    i_read = 1; i_addr = 32'h0000_0040;
    do_beat(64'h1, 0, 32'h0000_0040, 1'b0, 64'd0);
    do_beat(64'h2, 0, 32'h0000_0040, 1'b0, 64'd0);
    #1 rst = 1'b0;
    #1;
    chk("async_reset_pmem_read", 256'(pmem_read), 256'(0));
    chk("async_reset_resp", 256'({i_resp, d_resp}), 256'(0));
    chk("async_reset_i_rdata", i_rdata, 256'(0));
    i_read = 0;
    tick();
    rst = 1'b1;
    tick();
    i_read = 1; i_addr = 32'h0000_0300;
    q.push_back('{1'b0, 1'b1, rl});
    read_line(rl, 0, 32'h0000_0300);
    wait_resp(c1);
    i_read = 0;
    resp_low();

    tick();
    chk("scoreboard_drained", 256'(q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mp4_top.md
Name: mp4_top

Overview:
- Memory-side top level of the mp4 RV32I system: arbitration plus cacheline adaptation between the instruction cache, the data cache and one physical burst memory.
- Each cache issues whole-line (256-bit) read or write-back requests.
- The block serialises them onto a single 64-bit, 4-beat burst memory port and returns the assembled line to the requester.
- Sits directly between icache/dcache miss ports and the testbench burst memory (pmem_*).

Parameters:
- LINE_BITS, 256, cacheline width in bits.
- BEAT_BITS, 64, burst memory data width in bits.
- BEATS, LINE_BITS/BEAT_BITS (=4), beats per line transfer (derived; not user-set).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- i_read  input  1  icache line-fill request; held until i_resp.
- i_addr  input  32  icache request byte address.
- i_rdata  output  256  filled line to icache.
- i_resp  output  1  one-cycle completion pulse to icache.
- d_read  input  1  dcache line-fill request; held until d_resp.
- d_write  input  1  dcache write-back request; held until d_resp; never asserted with d_read.
- d_addr  input  32  dcache request byte address.
- d_wdata  input  256  write-back line.
- d_rdata  output  256  filled line to dcache.
- d_resp  output  1  one-cycle completion pulse to dcache.
- pmem_read  output  1  burst read request.
- pmem_write  output  1  burst write request.
- pmem_address  output  32  line-aligned burst address.
- pmem_wdata  output  64  current write beat.
- pmem_rdata  input  64  current read beat.
- pmem_resp  input  1  beat acknowledge, one per beat.

Behaviour:
- Reset (rst=0, async): state IDLE, beat counter 0, line buffer 0. All outputs 0 immediately; an in-flight burst is abandoned.
- States: IDLE, I_READ, D_READ, D_WRITE, DONE.
- IDLE grant rule: d_read -> D_READ, else d_write -> D_WRITE, else i_read -> I_READ. The dcache has fixed priority. Grant takes effect on the next clock edge.
- Latched on grant: requester, address, and for writes d_wdata. Later input changes are ignored until DONE.
- pmem_address = {addr[31:5], 5'b0} for the whole burst.
- Read states: pmem_read=1.
  - Each cycle with pmem_resp=1, store pmem_rdata into buffer bits [64k+63:64k] for beat k, then k++.
  - After beat 3: go to DONE and drop pmem_read.
- D_WRITE: pmem_write=1, pmem_wdata = latched line bits [64k+63:64k].
  - k advances on each pmem_resp.
  - After beat 3: go to DONE.
- Beats may be non-consecutive; the counter advances only on pmem_resp.
- DONE (exactly one cycle):
  - Pulse i_resp or d_resp for the served requester only.
  - i_rdata/d_rdata present the buffer; they hold their value until the next fill of the same port.
  - Then IDLE.
- Requester drops its request on the edge after the resp pulse, so IDLE never re-grants a completed request.
- pmem_read and pmem_write are never both 1. Neither is 1 in IDLE or DONE.
- Minimum request-to-resp latency: 1 (grant) + 4 beats + 1 (DONE) cycles.
- Back-to-back requests are each granted in the IDLE cycle following DONE.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined: when i_read and a dcache request are both pending in IDLE, grant the side not served last. A "last served" flag resets to icache, so the dcache wins the first tie.
- Not defined: fixed dcache priority as above.
- Non-tie grants are identical in both builds.

Test Plan:
- Icache fill: i_read=1, i_addr=0x0000_0064; memory returns 0x1111…, 0x2222…, 0x3333…, 0x4444… on 4 consecutive pmem_resp.
  - Required: pmem_address=0x0000_0060 throughout, pmem_read=1.
  - Required: i_rdata={0x4444…,0x3333…,0x2222…,0x1111…}, i_resp high exactly 1 cycle.
  - Total latency 6 cycles.
- Dcache write-back: d_write=1, d_addr=0x8000_00A4, d_wdata=256'h0123…FEDC.
  - Required: pmem_write=1, pmem_address=0x8000_00A0.
  - Required: pmem_wdata steps through bits [63:0],[127:64],[191:128],[255:192] on successive pmem_resp.
  - Required: d_resp pulses once, and i_resp stays 0.
- Simultaneous i_read and d_read in IDLE (fixed priority):
  - The dcache burst completes first, with d_resp.
  - The icache burst starts the cycle after DONE and ends with i_resp.
  - Under ARB_ROUND_ROBIN_EN after a prior dcache transfer, the icache goes first.
- Gapped beats: pmem_resp asserted with idle cycles between beats.
  - Required: beats stored in order; no resp until the 4th beat.
- Reset mid-burst: rst=0 after beat 2.
  - Required: pmem_read, i_resp and d_resp drop to 0 asynchronously.
  - Required: after release, a new i_read restarts at beat 0 and completes correctly.
- Request change mid-burst: i_addr changes during I_READ.
  - Required: pmem_address stays at the latched line address.
